// File: rtl/arbitrated_stream_mux_pkg.sv
// arbitrated_stream_mux_pkg: shared arbiter state encodings and index-width helper.
// Optional feature macro: ARB_STREAM_MUX_LOCK_EN adds the ARB_LOCKED state.
package arbitrated_stream_mux_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACTIVE = 2'd1
`ifdef ARB_STREAM_MUX_LOCK_EN
        ,
        ARB_LOCKED = 2'd2
`endif
    } arb_state_e;

    // Bits needed to index INPUTS requesters; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbitrated_stream_mux_picker.sv
// rr_priority_picker: combinational round-robin search over a request vector.
// Ports: req (requests), start (first index searched), hit (any request),
//        idx (winner index), onehot (winner one-hot, zero without hit).
module rr_priority_picker
    import arbitrated_stream_mux_pkg::*;
#(
    parameter int INPUTS = 4,
    localparam int IW = idx_width(INPUTS)
) (
    input  logic [INPUTS-1:0] req,
    input  logic [IW-1:0]     start,
    output logic              hit,
    output logic [IW-1:0]     idx,
    output logic [INPUTS-1:0] onehot
);

    // Explicit wrap so non-power-of-two INPUTS never aliases through truncation.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        return IW'((s > INPUTS - 1) ? s - INPUTS : s);
    endfunction

    // Scan from the farthest offset down so the nearest request to start wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = INPUTS - 1; k >= 0; k--) begin
            if (req[wrap_add(start, k)]) begin
                hit = 1'b1;
                idx = wrap_add(start, k);
            end
        end
        onehot = hit ? (INPUTS'(1) << idx) : '0;
    end

endmodule

// File: rtl/arbitrated_stream_mux.sv
// arbitrated_stream_mux: registered N-to-1 round-robin stream mux with valid/ready.
// Ports: clk, rst (async, active-high), req_valid/req_data/req_ready (sources),
//        out_valid/out_data/out_ready/out_source (sink), busy.
// Optional feature macro: ARB_STREAM_MUX_LOCK_EN adds req_lock and the locked state.
module arbitrated_stream_mux
    import arbitrated_stream_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int INPUTS = 4,
    parameter logic [WIDTH-1:0] DEFAULT = '0,
    localparam int IW = idx_width(INPUTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INPUTS-1:0]        req_valid,
    input  logic [WIDTH*INPUTS-1:0]  req_data,
`ifdef ARB_STREAM_MUX_LOCK_EN
    input  logic [INPUTS-1:0]        req_lock,
`endif
    output logic [INPUTS-1:0]        req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [INPUTS-1:0]        out_source,
    output logic                     busy
);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d, rr_ptr_q, rr_ptr_d, ptr_nxt, pick_start, pick_idx;
    logic [INPUTS-1:0] grant_oh_q, grant_oh_d, out_source_q, out_source_d, pick_oh;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d, space, xfer, lock_g, pick_hit;

    assign space   = !out_valid_q || out_ready;
    assign xfer    = (state_q != ARB_IDLE) && req_valid[grant_q] && space;
    assign ptr_nxt = (grant_q == IW'(INPUTS - 1)) ? '0 : grant_q + 1'b1;
    // After a transfer the re-pick starts just past the granted source.
    assign pick_start = xfer ? ptr_nxt : rr_ptr_q;
`ifdef ARB_STREAM_MUX_LOCK_EN
    assign lock_g = req_lock[grant_q];
`else
    assign lock_g = 1'b0;
`endif

    rr_priority_picker #(.INPUTS(INPUTS)) u_picker (
        .req    (req_valid),
        .start  (pick_start),
        .hit    (pick_hit),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_oh_d   = grant_oh_q;
        rr_ptr_d     = rr_ptr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_source_d = out_source_q;
        if (state_q == ARB_IDLE) begin
            if (pick_hit) begin
                state_d    = ARB_ACTIVE;
                grant_d    = pick_idx;
                grant_oh_d = pick_oh;
            end
        end else if (xfer) begin
            out_data_d   = req_data[int'(grant_q)*WIDTH +: WIDTH];
            out_source_d = grant_oh_q;
            rr_ptr_d     = ptr_nxt;
`ifdef ARB_STREAM_MUX_LOCK_EN
            if (lock_g) begin
                state_d = ARB_LOCKED;
            end else
`endif
            if (pick_hit) begin
                state_d    = ARB_ACTIVE;
                grant_d    = pick_idx;
                grant_oh_d = pick_oh;
            end else begin
                state_d = ARB_IDLE;
            end
        end else if (!req_valid[grant_q] && state_q == ARB_ACTIVE) begin
            // Source withdrew before its beat transferred: abandon without capture.
            state_d = ARB_IDLE;
        end
        // A capture in the same cycle as a drain keeps the register full.
        if (xfer) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
            out_source_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            grant_oh_q   <= '0;
            rr_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= DEFAULT;
            out_source_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_oh_q   <= grant_oh_d;
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_source_q <= out_source_d;
        end
    end

    assign req_ready  = (state_q != ARB_IDLE && space) ? grant_oh_q : '0;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_source = out_source_q;
    assign busy       = (state_q != ARB_IDLE) || out_valid_q;

    logic unused_lock;
    assign unused_lock = lock_g;

endmodule

// File: tb/tb_arbitrated_stream_mux.sv
// tb_arbitrated_stream_mux: table, hand-written and random checks against a reference model.
module tb_arbitrated_stream_mux;

    localparam int N = 4;
    localparam int W = 32;
    localparam logic [W-1:0] DEF = 32'h1234_5678;

    logic           clk, rst, out_ready, out_valid, busy;
    logic [N-1:0]   req_valid, req_ready, out_source;
    logic [W*N-1:0] req_data;
    logic [W-1:0]   out_data;
`ifdef ARB_STREAM_MUX_LOCK_EN
    logic [N-1:0]   req_lock;
`endif

    int checks = 0;
    int errors = 0;

    arbitrated_stream_mux #(.WIDTH(W), .INPUTS(N), .DEFAULT(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
`ifdef ARB_STREAM_MUX_LOCK_EN
        .req_lock   (req_lock),
`endif
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_source (out_source),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: "has a grant on source m_g", pointer, and the output register.
    bit         m_act;
    int         m_g, m_ptr;
    bit         m_ov;
    logic [W-1:0] m_od;
    logic [N-1:0] m_os;

    function automatic int mpick(input logic [N-1:0] r, input int s);
        for (int k = 0; k < N; k++)
            if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_act = 0; m_g = 0; m_ptr = 0; m_ov = 0; m_od = DEF; m_os = '0;
    endtask

    task automatic model_clk(input logic [N-1:0] rv, input logic ordy, input logic [W*N-1:0] d);
        bit sp, cap;
        int p;
        sp = !m_ov || ordy;
        cap = 0;
        if (!m_act) begin
            p = mpick(rv, m_ptr);
            if (p >= 0) begin m_act = 1; m_g = p; end
        end else if (rv[m_g] && sp) begin
            cap = 1;
            m_od = d[m_g*W +: W];
            m_os = N'(1 << m_g);
            m_ptr = (m_g + 1) % N;
            p = mpick(rv, m_ptr);
            if (p >= 0) m_g = p; else m_act = 0;
        end else if (!rv[m_g]) begin
            m_act = 0;
        end
        if (cap) m_ov = 1;
        else if (ordy) begin m_ov = 0; m_os = '0; end
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive inputs, let them settle, compare every output with the model.
    task automatic apply(input logic [N-1:0] rv, input logic ordy);
        logic [N-1:0] er;
        req_valid = rv;
        out_ready = ordy;
        #3;
        er = (m_act && (!m_ov || ordy)) ? N'(1 << m_g) : '0;
        chk("model req_ready", W'(req_ready), W'(er));
        chk("model out_valid", W'(out_valid), W'(m_ov));
        chk("model out_data", out_data, m_od);
        chk("model out_source", W'(out_source), W'(m_os));
        chk("model busy", W'(busy), W'(m_act || m_ov));
    endtask

    task automatic tick();
        @(posedge clk);
        model_clk(req_valid, out_ready, req_data);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] rv;
        logic         ordy;
        logic [N-1:0] err;
        logic         eov;
        logic [N-1:0] eos;
    } vec_t;

    vec_t tbl[22];

    initial begin
        tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 4'b0000};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000};
        tbl[5]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 4'b0000};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b1000};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0001};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0010};
        tbl[9]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'b0100};
        tbl[10] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'b1000};
        tbl[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'b1000};
        tbl[12] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b1000};
        tbl[13] = '{4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0001};
        tbl[14] = '{4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[15] = '{4'b0011, 1'b0, 4'b0010, 1'b0, 4'b0000};
        tbl[16] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 4'b0010};
        tbl[17] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 4'b0010};
        tbl[18] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 4'b0010};
        tbl[19] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0010};
        tbl[20] = '{4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0001};
        tbl[21] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000};

        req_valid = '0;
        out_ready = 1'b0;
`ifdef ARB_STREAM_MUX_LOCK_EN
        req_lock = '0;
`endif
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hA5A5_0000 | 32'(i);
        do_reset();
        chk("reset out_data", out_data, DEF);
        chk("reset out_valid", W'(out_valid), '0);
        chk("reset busy", W'(busy), '0);

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].rv, tbl[i].ordy);
            chk($sformatf("tbl%0d req_ready", i), W'(req_ready), W'(tbl[i].err));
            chk($sformatf("tbl%0d out_valid", i), W'(out_valid), W'(tbl[i].eov));
            chk($sformatf("tbl%0d out_source", i), W'(out_source), W'(tbl[i].eos));
            if (i == 3) chk("single source data", out_data, 32'hA5A5_0002);
            tick();
        end

        // Reset in the middle of a held beat clears everything at once.
        apply(4'b1111, 1'b0);
        tick();
        apply(4'b1111, 1'b0);
        tick();
        chk("pre-reset out_valid", W'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async reset out_valid", W'(out_valid), '0);
        chk("async reset out_data", out_data, DEF);
        chk("async reset req_ready", W'(req_ready), '0);
        chk("async reset out_source", W'(out_source), '0);
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = '0;
        model_reset();
        #1;
        chk("post-reset busy", W'(busy), '0);

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
            apply(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            tick();
        end

`ifdef ARB_STREAM_MUX_LOCK_EN
        do_reset();
        out_ready = 1'b1;
        req_lock = 4'b1000;
        req_valid = 4'b1000;
        @(posedge clk); #1;
        req_valid = 4'b1001;
        @(posedge clk); #1;
        chk("lock beat1", W'(out_source), 32'b1000);
        @(posedge clk); #1;
        chk("lock beat2", W'(out_source), 32'b1000);
        req_lock = 4'b0000;
        @(posedge clk); #1;
        chk("lock beat3", W'(out_source), 32'b1000);
        @(posedge clk); #1;
        chk("after unlock", W'(out_source), 32'b0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitrated_stream_mux.md
Name: arbitrated_stream_mux

Overview:
- Registered N-to-1 stream multiplexer with round-robin arbitration and valid/ready handshakes on every input and the output.
- Successor to the combinational one-hot select mux: the block itself chooses the source, holds the grant until the beat transfers, and buffers one beat in an output register.
- Sits between multiple bus masters or peripheral streams and a single shared sink, such as a Wishbone request channel or a UART transmit path.

Parameters:
- WIDTH, 32, data bits per channel.
- INPUTS, 4, number of requesters; legal range 2..16.
- DEFAULT, 0, value of out_data after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  INPUTS  per-source beat valid.
- req_data  in  WIDTH*INPUTS  packed source data; source i occupies [i*WIDTH +: WIDTH].
- req_ready  out  INPUTS  per-source accept; at most one bit high.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  output register data.
- out_ready  in  1  sink accepts out_data this cycle.
- out_source  out  INPUTS  one-hot index of the source of out_data; zero when out_valid=0.
- busy  out  1  high when state is not IDLE or out_valid=1.

Behaviour:
- Reset values: out_valid=0, out_data=DEFAULT, out_source=0, req_ready=0, state=IDLE, rr_ptr=0, grant=0.
- Round-robin pick: search starts at index rr_ptr and wraps at INPUTS-1 to 0; the first i with req_valid[i]=1 wins.
- space = !out_valid || out_ready. The output register accepts a new beat in the same cycle the old one drains, giving full throughput.
- State IDLE:
  - req_ready=0.
  - If any req_valid is high: grant<=pick, go to ACTIVE.
  - Grant latency is 1 cycle from first request.
- State ACTIVE (source g):
  - req_ready[g]=space.
  - Transfer = req_valid[g] && space. On transfer: out_data<=data[g], out_valid<=1, out_source<=onehot(g), rr_ptr<=(g+1) mod INPUTS.
  - Same cycle after a transfer, re-pick among current req_valid with the search starting at (g+1) mod INPUTS.
    - Hit: stay ACTIVE with the new grant; this gives back-to-back beats.
    - No hit: go to IDLE.
  - If req_valid[g] drops before transfer (protocol violation): go to IDLE, no beat is captured, rr_ptr is unchanged.
- Output side: out_valid && out_ready with no new capture gives out_valid<=0, out_source<=0. out_data keeps its last value.
- Simultaneous drain and capture: the capture wins, and out_valid stays 1.
- Fairness: a continuously requesting source waits at most INPUTS-1 beats.
- rst asserted mid-operation: all state returns to reset values immediately. The pending beat is lost and no req_ready pulse is produced.
- INPUTS not a power of two: the pointer wrap uses an explicit compare with INPUTS-1, never bit truncation.

Optional Feature:
- Macro ARB_STREAM_MUX_LOCK_EN.
- Defined:
  - Adds port req_lock in INPUTS.
  - Adds state LOCKED, entered from ACTIVE on a transfer where req_lock[g]=1.
  - In LOCKED the grant stays on g and no re-pick occurs. Each transfer with req_lock[g]=1 stays in LOCKED.
  - A transfer with req_lock[g]=0 is the final beat: it advances rr_ptr and re-picks as in ACTIVE.
  - Dropping req_valid[g] while LOCKED leaves the lock in place, waiting for g.
- Undefined: no req_lock port and no LOCKED state; every beat is re-arbitrated.

Decomposition:
- Shared package/header holds:
  - state encodings ARB_IDLE=2'd0, ARB_ACTIVE=2'd1, ARB_LOCKED=2'd2.
  - the $clog2-based index width for INPUTS.
- One combinational sub-module, rr_priority_picker (parameter INPUTS).
  - Inputs: request vector, start pointer.
  - Outputs: hit, winner index, one-hot winner.
  - Used both for the IDLE pick and for the ACTIVE re-pick.

Test Plan:
- Reset: assert rst mid-transfer with out_valid=1 → same cycle out_valid=0, out_data=DEFAULT, req_ready=0; after release busy=0.
- Single source: req_valid=4'b0100, data[2]=32'hA5A5_0002, out_ready=1 → req_ready[2] high 1 cycle after request; out_data=32'hA5A5_0002, out_source=4'b0100 the cycle after transfer.
- Round-robin: all four valid continuously, out_ready=1 → out_source sequence 0001,0010,0100,1000,0001, one beat per cycle after the first.
- Backpressure: out_ready=0 for 5 cycles with a beat held → req_ready all 0, out_data stable. Release → next beat captured the same cycle as the drain.
- Protocol abandon: grant source 1, drop req_valid[1] before space → state IDLE, out_valid unchanged, rr_ptr unchanged; next pick still favours source 1.
- Lock (ARB_STREAM_MUX_LOCK_EN): source 3 sends 3 beats with req_lock=1,1,0 while source 0 requests → out_source 1000 ×3, then 0001.
